univ_shift_register: RTL
========================

Name: univ_shift_register

Overview:
- Parametrised successor to the team's 8-bit enable/output-gated register.
- Holds a WIDTH-bit word with:
  - parallel load
  - single-bit shift and rotate
  - multi-cycle N-bit shift under an FSM with BUSY/DONE handshake
  - a shadow (save/restore) register
  - active-low output gating
- Used as the general datapath register in later lab designs: accumulator, serial converter, and operand holding.

Parameters:
WIDTH, 8, data word width (>=2)
SHW, 4, width of SHAMT; must satisfy 2**SHW > WIDTH

Ports:
CLOCK  in  1  clock; all state updates on the falling edge
RESET  in  1  asynchronous, active-low reset
DATA  in  WIDTH  parallel load data
MODE  in  3  operation select (encoding below)
EWR  in  1  active-low command strobe; sampled at each falling edge
SHAMT  in  SHW  shift amount for the multi-cycle modes
SIN_L  in  1  serial fill bit entering at the MSB (right shifts)
SIN_R  in  1  serial fill bit entering at the LSB (left shifts)
SAVE  in  1  active-high; copy the working register into the shadow register
RESTORE  in  1  active-high; copy the shadow register into the working register
EDY  in  1  active-low output enable
OUTRESULT  out  WIDTH  working register when EDY=0; all zeros when EDY=1 (combinational)
BUF  out  WIDTH  shadow register, ungated
SOUT_L  out  1  working register MSB
SOUT_R  out  1  working register LSB
BUSY  out  1  registered; high while in SHIFT
DONE  out  1  registered; single-cycle pulse in the DONE state

Behaviour:
- Clocking and reset
  - Single clock domain.
  - RESET low asynchronously forces: working register=0, shadow=0, state=IDLE, counter=0, BUSY=0, DONE=0.
  - Release is sampled at the next falling edge.
- MODE encoding
  - 000 HOLD
  - 001 LOAD (reg=DATA)
  - 010 SHL1 (reg={reg[W-2:0],SIN_R})
  - 011 SHR1 (reg={SIN_L,reg[W-1:1]})
  - 100 ROL1
  - 101 ROR1
  - 110 SHLN
  - 111 SHRN
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - Commands are accepted only in IDLE with EWR=0.
  - Modes 000-101 complete at the accepting edge, so the new value is visible right after that edge; the state stays IDLE.
  - SHLN/SHRN at the accepting edge E0:
    - counter = min(SHAMT, WIDTH)
    - if the counter is nonzero, go to SHIFT, otherwise go to DONE
    - the latched direction is held internally
- SHIFT
  - Each edge shifts one bit in the latched direction, fills from SIN_R (left) or SIN_L (right), and decrements the counter.
  - On the edge where the counter reaches 0, go to DONE.
  - A k-bit shift completes at edge Ek; BUSY is high between E0 and Ek.
- DONE
  - DONE=1 for exactly one cycle, then IDLE.
  - A new command can be accepted at that same next edge only if the FSM is already in IDLE, so DONE itself accepts no command.
- Ignored inputs
  - In SHIFT and DONE, EWR, MODE, SHAMT, SAVE and RESTORE are ignored.
  - DATA is not sampled.
- Shadow register, IDLE only
  - SAVE=1: shadow <= working register value before this edge's update.
  - RESTORE=1: working register <= shadow. RESTORE overrides any EWR command on the same edge.
  - SAVE and RESTORE together: the two registers swap.
- Width rules
  - SHAMT > WIDTH is clamped to WIDTH; the result is fully serial-filled.
  - Rotates have no serial input.
- Reset mid-shift: aborts immediately to the reset values; no DONE pulse is produced.
- OUTRESULT gating by EDY is combinational and independent of the FSM.

Decomposition:
- Shared package `usr_pkg` holds:
  - MODE localparams (M_HOLD, M_LOAD, M_SHL1, M_SHR1, M_ROL1, M_ROR1, M_SHLN, M_SHRN)
  - FSM state encodings (S_IDLE, S_SHIFT, S_DONE)
- One combinational sub-module, `usr_next_value`: (reg, mode, DATA, SIN_L, SIN_R) -> next reg.
  - Reused for both single-step and per-cycle N-shift.
- FSM, counter and shadow register stay in the top module.

Test Plan:
- RESET=0 mid-operation with reg=8'hA5 -> OUTRESULT=0, BUF=0, BUSY=0 at once, without waiting for a clock.
- EWR=0, MODE=LOAD, DATA=8'h3C; next cycle EDY=1 then EDY=0 -> OUTRESULT 8'h00, then 8'h3C; SOUT_L=0, SOUT_R=0.
- reg=8'h81, ROL1 -> 8'h03; then SHR1 with SIN_L=1 -> 8'h81.
- reg=8'h01, SHLN, SHAMT=3, SIN_R=0 -> BUSY high for 3 cycles, reg=8'h08 at E3, DONE pulse one cycle later, then IDLE; an EWR/LOAD pulse during BUSY is ignored.
- reg=8'hFF, SHRN, SHAMT=12, SIN_L=0 -> clamps to 8 shifts, reg=8'h00, BUSY 8 cycles. SHAMT=0 -> BUSY never asserts, DONE pulses the cycle after E0.
- reg=8'h55, shadow=8'hAA, SAVE=1 and RESTORE=1 together -> reg=8'hAA, BUF=8'h55. SAVE=1 with LOAD DATA=8'h11 -> BUF=8'hAA (the old reg value), reg=8'h11.

Source files
------------

// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usr_pkg
// Description : Shared operation codes and FSM state encoding for the
//               universal shift register.
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

  // Operation select codes carried on MODE
  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL1 = 3'b010;
  localparam logic [2:0] M_SHR1 = 3'b011;
  localparam logic [2:0] M_ROL1 = 3'b100;
  localparam logic [2:0] M_ROR1 = 3'b101;
  localparam logic [2:0] M_SHLN = 3'b110;
  localparam logic [2:0] M_SHRN = 3'b111;

  // Sequencer states for the multi-cycle shift
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/univ_shift_register_if.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_register_if
// Description : Command/data bundle for the universal shift register.
//               master drives commands and data, slave is the register.
// Revision    : 1.0 - initial release
// ============================================================================
interface univ_shift_register_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
);

  logic [WIDTH-1:0] DATA;
  logic [2:0]       MODE;
  logic             EWR;
  logic [SHW-1:0]   SHAMT;
  logic             SIN_L;
  logic             SIN_R;
  logic             SAVE;
  logic             RESTORE;
  logic             EDY;
  logic [WIDTH-1:0] OUTRESULT;
  logic [WIDTH-1:0] BUF;
  logic             SOUT_L;
  logic             SOUT_R;
  logic             BUSY;
  logic             DONE;

  modport master (
    output DATA, MODE, EWR, SHAMT, SIN_L, SIN_R, SAVE, RESTORE, EDY,
    input  OUTRESULT, BUF, SOUT_L, SOUT_R, BUSY, DONE
  );

  modport slave (
    input  DATA, MODE, EWR, SHAMT, SIN_L, SIN_R, SAVE, RESTORE, EDY,
    output OUTRESULT, BUF, SOUT_L, SOUT_R, BUSY, DONE
  );

endinterface
`default_nettype wire

// File: rtl/usr_next_value.sv
`default_nettype none
// ============================================================================
// Module      : usr_next_value
// Description : Pure combinational next-word function. Serves both the
//               single-step modes and each step of the N-bit shift, where
//               SHLN/SHRN behave as a single one-bit shift.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_next_value
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] nxt
);

  // Select the new word for the requested operation
  always_comb begin
    nxt = cur;
    case (mode)
      M_HOLD:         nxt = cur;
      M_LOAD:         nxt = data;
      M_SHL1, M_SHLN: nxt = {cur[WIDTH-2:0], sin_r};
      M_SHR1, M_SHRN: nxt = {sin_l, cur[WIDTH-1:1]};
      M_ROL1:         nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROR1:         nxt = {cur[0], cur[WIDTH-1:1]};
      default:        nxt = cur;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/univ_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_register
// Description : WIDTH-bit working register with load, shift/rotate, a
//               sequenced N-bit shift with BUSY/DONE, a save/restore shadow
//               register and active-low output gating. State changes on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  univ_shift_register_if.slave  bus
);

  localparam logic [SHW-1:0] MAX_AMT = SHW'(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nx;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_nx;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   cnt_nx;
  logic             dir;      // 0 = left, 1 = right
  logic             dir_nx;
  logic             busy;
  logic             done;
  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_val;
  logic [SHW-1:0]   amt;

  // Shift amounts beyond the word width saturate to a full serial fill
  assign amt = (bus.SHAMT > MAX_AMT) ? MAX_AMT : bus.SHAMT;

  // While shifting, the latched direction replaces whatever is on MODE
  always_comb begin
    step_mode = bus.MODE;
    if (state == S_SHIFT) begin
      step_mode = dir ? M_SHRN : M_SHLN;
    end
  end

  usr_next_value #(
    .WIDTH (WIDTH)
  ) u_next_value (
    .cur   (work),
    .mode  (step_mode),
    .data  (bus.DATA),
    .sin_l (bus.SIN_L),
    .sin_r (bus.SIN_R),
    .nxt   (step_val)
  );

  // Next-state, datapath and shadow decisions
  always_comb begin
    state_nx  = state;
    work_nx   = work;
    shadow_nx = shadow;
    cnt_nx    = cnt;
    dir_nx    = dir;
    case (state)
      S_IDLE: begin
        // SAVE captures the pre-edge value, so SAVE+RESTORE swaps
        if (bus.SAVE) begin
          shadow_nx = work;
        end
        if (bus.RESTORE) begin
          work_nx = shadow;
        end else if (!bus.EWR) begin
          if (bus.MODE == M_SHLN || bus.MODE == M_SHRN) begin
            dir_nx   = (bus.MODE == M_SHRN);
            cnt_nx   = amt;
            state_nx = (amt != '0) ? S_SHIFT : S_DONE;
          end else begin
            work_nx = step_val;
          end
        end
      end
      S_SHIFT: begin
        work_nx = step_val;
        cnt_nx  = cnt - 1'b1;
        if (cnt == SHW'(1)) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; BUSY/DONE are registered decodes of next state
  always_ff @(negedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state  <= S_IDLE;
      work   <= '0;
      shadow <= '0;
      cnt    <= '0;
      dir    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      work   <= work_nx;
      shadow <= shadow_nx;
      cnt    <= cnt_nx;
      dir    <= dir_nx;
      busy   <= (state_nx == S_SHIFT);
      done   <= (state_nx == S_DONE);
    end
  end

  assign bus.OUTRESULT = bus.EDY ? '0 : work;
  assign bus.BUF       = shadow;
  assign bus.SOUT_L    = work[WIDTH-1];
  assign bus.SOUT_R    = work[0];
  assign bus.BUSY      = busy;
  assign bus.DONE      = done;

endmodule
`default_nettype wire
